// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and constants for edge_event_arbiter and its sub-modules.
package edge_event_arbiter_pkg;

  localparam int EEA_N_DEFAULT = 4;

  typedef enum logic {IDLE, OFFER} arb_state_t;

  // Round-robin successor; explicit modulo so non-power-of-two N wraps correctly.
  function automatic int unsigned next_ptr(int unsigned id, int unsigned n);
    return (id + 1 == n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_rr_picker.sv
// rr_picker: combinational search for the first requester at or after ptr, wrapping modulo N.
module rr_picker
  import edge_event_arbiter_pkg::*;
#(
  parameter  int N   = EEA_N_DEFAULT,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  int unsigned j;

  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % 32'(N);
      if (!any && req[j]) begin
        any = 1'b1;
        idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/posedge_detector.sv
// Single-bit rising-edge detector: rise is high for the cycle where a is 1 and was 0.
module posedge_detector (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic rise
);

  logic a_r;

  always_ff @(posedge clk) begin
    if (rst) a_r <= 1'b0;
    else     a_r <= a;
  end

  assign rise = a & ~a_r;

endmodule

// File: rtl/edge_event_arbiter.sv
// Serialises rising edges on N level inputs onto one valid/ready ID channel, round-robin.
// Define EDGE_EVENT_ARBITER_OVF_EN to add the sticky per-channel drop flags (ovf port).
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter  int N   = EEA_N_DEFAULT,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   a,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [IDW-1:0] out_id,
`ifdef EDGE_EVENT_ARBITER_OVF_EN
  output logic [N-1:0]   ovf,
`endif
  output logic [N-1:0]   pending
);

  arb_state_t     state;
  logic [IDW-1:0] ptr;
  logic [N-1:0]   e;
  logic [N-1:0]   grant_hit;
  logic           xfer;
  logic           pick_any;
  logic [IDW-1:0] pick_idx;

  for (genvar i = 0; i < N; i++) begin : g_edge
    posedge_detector u_det (
      .clk  (clk),
      .rst  (rst),
      .a    (a[i]),
      .rise (e[i])
    );
  end

  rr_picker #(.N(N)) u_pick (
    .req (pending),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign xfer = out_valid & out_ready;

  always_comb begin
    grant_hit = '0;
    for (int unsigned i = 0; i < N; i++)
      grant_hit[i] = xfer && (32'(out_id) == i);
  end

  // A new edge wins over the clear, so an edge coincident with its own grant re-arms.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (e[i])              pending[i] <= 1'b1;
        else if (grant_hit[i]) pending[i] <= 1'b0;
      end
    end
  end

`ifdef EDGE_EVENT_ARBITER_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) ovf <= '0;
    else     ovf <= ovf | (e & pending & ~grant_hit);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_id    <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            out_id    <= pick_idx;
            out_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ptr       <= IDW'(next_ptr(32'(out_id), N));
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed table-driven bench for edge_event_arbiter (N=4); ovf checks follow EDGE_EVENT_ARBITER_OVF_EN.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] out_id;
  logic [3:0] pending;
`ifdef EDGE_EVENT_ARBITER_OVF_EN
  logic [3:0] ovf;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  edge_event_arbiter #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
`ifdef EDGE_EVENT_ARBITER_OVF_EN
    .ovf       (ovf),
`endif
    .pending   (pending)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  a;
    logic        rdy;
    int unsigned rep;
    logic        v;
    logic [1:0]  id;
    logic [3:0]  p;
    logic [3:0]  ovf;
  } vec_t;

  vec_t vt[$];

  function automatic void add(logic r, logic [3:0] av, logic rd, int unsigned rep,
                              logic v, logic [1:0] id, logic [3:0] p, logic [3:0] o);
    vec_t x;
    x.rst = r; x.a = av; x.rdy = rd; x.rep = rep;
    x.v = v; x.id = id; x.p = p; x.ovf = o;
    vt.push_back(x);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(logic r, logic [3:0] av, logic rd);
    @(negedge clk);
    rst = r; a = av; out_ready = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; a = '0; out_ready = 1'b0;

    // rst a rdy rep | valid id pending ovf
    add(1, 4'b0000, 0, 2,  0, 0, 4'b0000, 4'b0000);
    // single event on channel 2
    add(0, 4'b0000, 1, 1,  0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0100, 1, 1,  0, 0, 4'b0100, 4'b0000);
    add(0, 4'b0000, 1, 1,  1, 2, 4'b0100, 4'b0000);
    add(0, 4'b0000, 1, 1,  0, 2, 4'b0000, 4'b0000);
    // fairness from ptr=0
    add(1, 4'b0000, 1, 1,  0, 0, 4'b0000, 4'b0000);
    add(0, 4'b1111, 1, 1,  0, 0, 4'b1111, 4'b0000);
    add(0, 4'b1111, 1, 1,  1, 0, 4'b1111, 4'b0000);
    add(0, 4'b1111, 1, 1,  0, 0, 4'b1110, 4'b0000);
    add(0, 4'b1111, 1, 1,  1, 1, 4'b1110, 4'b0000);
    add(0, 4'b1111, 1, 1,  0, 1, 4'b1100, 4'b0000);
    add(0, 4'b1111, 1, 1,  1, 2, 4'b1100, 4'b0000);
    add(0, 4'b1111, 1, 1,  0, 2, 4'b1000, 4'b0000);
    add(0, 4'b1111, 1, 1,  1, 3, 4'b1000, 4'b0000);
    add(0, 4'b1111, 1, 1,  0, 3, 4'b0000, 4'b0000);
    // re-raise 0 and 3 with ptr wrapped to 0
    add(0, 4'b0000, 1, 1,  0, 3, 4'b0000, 4'b0000);
    add(0, 4'b1001, 1, 1,  0, 3, 4'b1001, 4'b0000);
    add(0, 4'b1001, 1, 1,  1, 0, 4'b1001, 4'b0000);
    add(0, 4'b1001, 1, 1,  0, 0, 4'b1000, 4'b0000);
    add(0, 4'b1001, 1, 1,  1, 3, 4'b1000, 4'b0000);
    add(0, 4'b1001, 1, 1,  0, 3, 4'b0000, 4'b0000);
    // back-pressure on id 1, a[0] rises during the stall
    add(0, 4'b0000, 0, 1,  0, 3, 4'b0000, 4'b0000);
    add(0, 4'b0010, 0, 1,  0, 3, 4'b0010, 4'b0000);
    add(0, 4'b0010, 0, 3,  1, 1, 4'b0010, 4'b0000);
    add(0, 4'b0011, 0, 7,  1, 1, 4'b0011, 4'b0000);
    add(0, 4'b0011, 1, 1,  0, 1, 4'b0001, 4'b0000);
    add(0, 4'b0011, 1, 1,  1, 0, 4'b0001, 4'b0000);
    add(0, 4'b0011, 1, 1,  0, 0, 4'b0000, 4'b0000);
    // edge coincident with its own transfer: re-armed, no drop
    add(0, 4'b0000, 0, 1,  0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0010, 0, 1,  0, 0, 4'b0010, 4'b0000);
    add(0, 4'b0000, 0, 1,  1, 1, 4'b0010, 4'b0000);
    add(0, 4'b0010, 1, 1,  0, 1, 4'b0010, 4'b0000);
    add(0, 4'b0010, 1, 1,  1, 1, 4'b0010, 4'b0000);
    add(0, 4'b0000, 1, 1,  0, 1, 4'b0000, 4'b0000);
    // second edge while stalled is merged and flagged
    add(0, 4'b0010, 0, 1,  0, 1, 4'b0010, 4'b0000);
    add(0, 4'b0010, 0, 1,  1, 1, 4'b0010, 4'b0000);
    add(0, 4'b0000, 0, 1,  1, 1, 4'b0010, 4'b0000);
    add(0, 4'b0010, 0, 1,  1, 1, 4'b0010, 4'b0010);
    add(0, 4'b0010, 1, 1,  0, 1, 4'b0000, 4'b0010);
    add(0, 4'b0010, 1, 2,  0, 1, 4'b0000, 4'b0010);
    // reset during OFFER with three pending; a[3] held through reset
    add(0, 4'b0000, 0, 1,  0, 1, 4'b0000, 4'b0010);
    add(0, 4'b1011, 0, 1,  0, 1, 4'b1011, 4'b0010);
    add(0, 4'b1011, 0, 1,  1, 3, 4'b1011, 4'b0010);
    add(1, 4'b1000, 0, 1,  0, 0, 4'b0000, 4'b0000);
    add(0, 4'b1000, 0, 1,  0, 0, 4'b1000, 4'b0000);
    add(0, 4'b1000, 0, 1,  1, 3, 4'b1000, 4'b0000);
    add(0, 4'b1000, 1, 1,  0, 3, 4'b0000, 4'b0000);
    add(0, 4'b1000, 1, 2,  0, 3, 4'b0000, 4'b0000);

    for (int i = 0; i < vt.size(); i++) begin
      for (int unsigned r = 0; r < vt[i].rep; r++) begin
        step(vt[i].rst, vt[i].a, vt[i].rdy);
        chk($sformatf("row%0d.%0d out_valid", i, r), 32'(out_valid), 32'(vt[i].v));
        chk($sformatf("row%0d.%0d pending", i, r), 32'(pending), 32'(vt[i].p));
        if (vt[i].v)
          chk($sformatf("row%0d.%0d out_id", i, r), 32'(out_id), 32'(vt[i].id));
`ifdef EDGE_EVENT_ARBITER_OVF_EN
        chk($sformatf("row%0d.%0d ovf", i, r), 32'(ovf), 32'(vt[i].ovf));
`endif
      end
    end

    // ptr is 0 here: pulse a[2] and wait a bounded time for its offer
    step(0, 4'b0000, 0);
    step(0, 4'b0100, 0);
    step(0, 4'b0000, 0);
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      if (out_valid) seen = 1'b1;
      else step(0, 4'b0000, 0);
    end
    chk("timeout waiting out_valid", 32'(seen), 32'd1);
    if (seen) chk("late offer out_id", 32'(out_id), 32'd2);
    step(0, 4'b0000, 0);
    chk("offer held under stall", 32'(out_valid), 32'd1);
    step(0, 4'b0000, 1);
    chk("late offer accepted", 32'(out_valid), 32'd0);
    chk("late offer pending cleared", 32'(pending), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
